pwm_multichannel: RTL and testbench

Parametrised multi-channel PWM generator. It replaces the fixed 16-output, fixed-divider, single-duty PWM peripheral.
- Each channel has its own duty register, double-buffered so duty changes are glitch-free.
- Prescaler and period are programmable; counting is edge- or centre-aligned.
- Output polarity is per channel.
- Sits behind the SPI register file; drives uo_out/uio_out.

---
 rtl/pwm_multichannel.sv | 169 ++++++++++++++++
 tb/tb_pwm_multichannel.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multichannel.sv
// pwm_multichannel: N-channel PWM, shadowed period/mode, double-buffered duty.
// Optional sticky period interrupt when PWM_IRQ_EN is defined.
module pwm_multichannel #(
  parameter int NUM_CH = 16,
  parameter int CNT_W  = 8,
  parameter int DIV_W  = 12,
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [DIV_W-1:0]  prescale,
  input  logic [CNT_W-1:0]  period,
  input  logic              center_mode,
  input  logic              duty_wr,
  input  logic [SEL_W-1:0]  duty_sel,
  input  logic [CNT_W-1:0]  duty_wdata,
  input  logic [NUM_CH-1:0] out_en,
  input  logic [NUM_CH-1:0] pwm_en,
  input  logic [NUM_CH-1:0] polarity,
  output logic [NUM_CH-1:0] out,
`ifdef PWM_IRQ_EN
  input  logic              irq_clr,
  output logic              irq,
`endif
  output logic              period_start
);

  logic [DIV_W-1:0]  div_q;
  logic              tick;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              dir_q;
  logic              dir_d;
  logic              wrap;
  logic              boundary;
  logic [CNT_W-1:0]  period_a;
  logic              mode_a;
  logic [CNT_W-1:0]  duty_p [NUM_CH];
  logic [CNT_W-1:0]  duty_a [NUM_CH];
  logic [NUM_CH-1:0] wave;
  logic [NUM_CH-1:0] out_d;
  logic              sel_ok;

  assign tick     = (div_q == prescale);
  assign boundary = ena & tick & wrap;
  assign sel_ok   = ({1'b0, duty_sel} < (SEL_W+1)'(NUM_CH));

  // Prescaler: 0..prescale, out-of-range value falls back to 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
    end else if (ena) begin
      if (div_q >= prescale) div_q <= '0;
      else                   div_q <= div_q + DIV_W'(1);
    end
  end

  // Counter next state; wrap marks the tick that returns cnt to 0
  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    wrap  = 1'b0;
    if (!mode_a) begin
      dir_d = 1'b0;
      if (cnt_q >= period_a) begin
        cnt_d = '0;
        wrap  = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (!dir_q) begin
      if (cnt_q < period_a) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else if (cnt_q <= CNT_W'(1)) begin
        cnt_d = '0;
        wrap  = 1'b1;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
        dir_d = 1'b1;
      end
    end else begin
      if (cnt_q <= CNT_W'(1)) begin
        cnt_d = '0;
        dir_d = 1'b0;
        wrap  = 1'b1;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  // Counter state register, advances on tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      dir_q <= 1'b0;
    end else if (ena && tick) begin
      cnt_q <= cnt_d;
      dir_q <= dir_d;
    end
  end

  // Shadowed period/mode load and period_start pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_a     <= '0;
      mode_a       <= 1'b0;
      period_start <= 1'b0;
    end else if (ena) begin
      period_start <= boundary;
      if (boundary) begin
        period_a <= period;
        mode_a   <= center_mode;
      end
    end
  end

  // Duty pending/active pair; a write on a boundary lands in pending only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        duty_p[i] <= '0;
        duty_a[i] <= '0;
      end
    end else if (ena) begin
      if (boundary) begin
        for (int i = 0; i < NUM_CH; i++)
          duty_a[i] <= duty_p[i];
      end
      if (duty_wr && sel_ok)
        duty_p[duty_sel] <= duty_wdata;
    end
  end

  // Raw waveform and output mux
  always_comb begin
    wave  = '0;
    out_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wave[i] = (cnt_q < duty_a[i]);
      unique case (1'b1)
        !out_en[i]:
          out_d[i] = 1'b0;
        out_en[i] && !pwm_en[i]:
          out_d[i] = 1'b1;
        out_en[i] && pwm_en[i]:
          out_d[i] = wave[i] ^ polarity[i];
        default:
          out_d[i] = 1'b0;
      endcase
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   out <= '0;
    else if (ena) out <= out_d;
  end

`ifdef PWM_IRQ_EN
  // Sticky irq: set by period_start, which wins over clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   irq <= 1'b0;
    else if (ena) irq <= period_start | (irq & ~irq_clr);
  end
`endif

endmodule

// File: tb/tb_pwm_multichannel.sv
// tb_pwm_multichannel: table-driven waveform vectors plus
// shadowing, prescale, freeze and reset sequences.
module tb_pwm_multichannel;
  localparam int NUM_CH = 16;
  localparam int CNT_W  = 8;
  localparam int DIV_W  = 12;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ena;
  logic [DIV_W-1:0]  prescale;
  logic [CNT_W-1:0]  period;
  logic              center_mode;
  logic              duty_wr;
  logic [3:0]        duty_sel;
  logic [CNT_W-1:0]  duty_wdata;
  logic [NUM_CH-1:0] out_en;
  logic [NUM_CH-1:0] pwm_en;
  logic [NUM_CH-1:0] polarity;
  logic [NUM_CH-1:0] out;
  logic              period_start;
  logic              irq_clr;
  logic              irq;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pwm_multichannel #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .DIV_W(DIV_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .prescale(prescale), .period(period),
    .center_mode(center_mode), .duty_wr(duty_wr),
    .duty_sel(duty_sel), .duty_wdata(duty_wdata),
    .out_en(out_en), .pwm_en(pwm_en),
    .polarity(polarity), .out(out),
`ifdef PWM_IRQ_EN
    .irq_clr(irq_clr), .irq(irq),
`endif
    .period_start(period_start)
  );

`ifndef PWM_IRQ_EN
  assign irq = 1'b0;
`endif

  typedef struct {
    logic [7:0]  period;
    logic        center;
    logic [7:0]  duty;
    logic        pol;
    logic        pe;
    logic        oe;
    int          exp_len;
    logic [31:0] exp_pat;
  } vec_t;

  localparam int NV = 12;
  vec_t vt [NV];

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_duty(input logic [3:0] ch,
                            input logic [7:0] v);
    duty_sel   = ch;
    duty_wdata = v;
    duty_wr    = 1'b1;
    step(1);
    duty_wr    = 1'b0;
  endtask

  task automatic wait_ps(input string nm);
    int k;
    k = 0;
    do begin
      step(1);
      k++;
    end while (!period_start && k < 300);
    if (!period_start) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: period_start got 0 expected 1 within 300", nm);
    end
  endtask

  // Call at a period_start cycle; records ch0 until the next one.
  task automatic measure(input int wr_at,
                         input logic [7:0] wr_val,
                         output int len,
                         output logic [31:0] pat,
                         output int highs);
    len   = 0;
    pat   = '0;
    highs = 0;
    for (int k = 0; k < 200; k++) begin
      if (k == wr_at) begin
        duty_sel   = 4'd0;
        duty_wdata = wr_val;
        duty_wr    = 1'b1;
      end
      step(1);
      duty_wr = 1'b0;
      if (k < 32) pat[k] = out[0];
      if (out[0]) highs++;
      if (period_start) begin
        len = k + 1;
        break;
      end
    end
  endtask

  initial begin
    int          len;
    int          h;
    int          n;
    logic [31:0] pat;
    logic [15:0] o;
    logic        frz_ok;

    vt[0]  = '{8'd9, 1'b0, 8'd3,  1'b0, 1'b1, 1'b1, 10, 32'h007};
    vt[1]  = '{8'd9, 1'b0, 8'd0,  1'b0, 1'b1, 1'b1, 10, 32'h000};
    vt[2]  = '{8'd9, 1'b0, 8'd10, 1'b0, 1'b1, 1'b1, 10, 32'h3FF};
    vt[3]  = '{8'd9, 1'b0, 8'd3,  1'b1, 1'b1, 1'b1, 10, 32'h3F8};
    vt[4]  = '{8'd4, 1'b1, 8'd2,  1'b0, 1'b1, 1'b1, 8,  32'h083};
    vt[5]  = '{8'd4, 1'b1, 8'd5,  1'b0, 1'b1, 1'b1, 8,  32'h0FF};
    vt[6]  = '{8'd1, 1'b1, 8'd1,  1'b0, 1'b1, 1'b1, 2,  32'h001};
    vt[7]  = '{8'd0, 1'b0, 8'd1,  1'b0, 1'b1, 1'b1, 1,  32'h001};
    vt[8]  = '{8'd0, 1'b1, 8'd0,  1'b0, 1'b1, 1'b1, 1,  32'h000};
    vt[9]  = '{8'd9, 1'b0, 8'd3,  1'b0, 1'b0, 1'b1, 10, 32'h3FF};
    vt[10] = '{8'd9, 1'b0, 8'd3,  1'b0, 1'b1, 1'b0, 10, 32'h000};
    vt[11] = '{8'd6, 1'b1, 8'd3,  1'b1, 1'b1, 1'b1, 12, 32'h3F8};

    rst_n       = 1'b0;
    ena         = 1'b0;
    prescale    = '0;
    period      = '0;
    center_mode = 1'b0;
    duty_wr     = 1'b0;
    duty_sel    = '0;
    duty_wdata  = '0;
    out_en      = '0;
    pwm_en      = '0;
    polarity    = '0;
    irq_clr     = 1'b0;

    step(2);
    check("rst_out", 32'(out), 32'h0);
    check("rst_ps", 32'(period_start), 32'h0);

    rst_n  = 1'b1;
    ena    = 1'b1;
    out_en = 16'h00F0;
    step(2);
    check("static_out", 32'(out), 32'h00F0);

    for (int i = 0; i < NV; i++) begin
      period      = vt[i].period;
      center_mode = vt[i].center;
      out_en[0]   = vt[i].oe;
      pwm_en[0]   = vt[i].pe;
      polarity[0] = vt[i].pol;
      write_duty(4'd0, vt[i].duty);
      wait_ps($sformatf("v%0d_sync", i));
      measure(-1, 8'd0, len, pat, h);
      check($sformatf("v%0d_len", i), 32'(len), 32'(vt[i].exp_len));
      check($sformatf("v%0d_pat", i), pat, vt[i].exp_pat);
    end

    period      = 8'd9;
    center_mode = 1'b0;
    out_en[0]   = 1'b1;
    pwm_en[0]   = 1'b1;
    polarity[0] = 1'b0;
    write_duty(4'd0, 8'd2);
    wait_ps("sh_sync");
    measure(-1, 8'd0, len, pat, h);
    check("sh_base", pat, 32'h003);
    measure(4, 8'd7, len, pat, h);
    check("sh_mid_old", pat, 32'h003);
    measure(-1, 8'd0, len, pat, h);
    check("sh_mid_new", pat, 32'h07F);
    measure(9, 8'd5, len, pat, h);
    check("sh_bnd_cur", pat, 32'h07F);
    measure(-1, 8'd0, len, pat, h);
    check("sh_bnd_hold", pat, 32'h07F);
    measure(-1, 8'd0, len, pat, h);
    check("sh_bnd_new", pat, 32'h01F);

    prescale = 12'd3;
    wait_ps("ps_sync");
    measure(-1, 8'd0, len, pat, h);
    check("pre_len", 32'(len), 32'd40);
    check("pre_high", 32'(h), 32'd20);

    step(6);
    o      = out;
    frz_ok = !period_start;
    ena    = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step(1);
      if (out !== o || period_start) frz_ok = 1'b0;
    end
    ena = 1'b1;
    check("frz_hold", 32'(frz_ok), 32'h1);
    n = 0;
    do begin
      step(1);
      n++;
    end while (!period_start && n < 200);
    check("frz_resume", 32'(n), 32'd34);

`ifdef PWM_IRQ_EN
    check("irq_set", 32'(irq), 32'h1);
    step(1);
    irq_clr = 1'b1;
    step(1);
    irq_clr = 1'b0;
    check("irq_clr", 32'(irq), 32'h0);
    wait_ps("irq_sync");
    irq_clr = 1'b1;
    step(1);
    irq_clr = 1'b0;
    check("irq_set_wins", 32'(irq), 32'h1);
    irq_clr = 1'b1;
    step(1);
    irq_clr = 1'b0;
    check("irq_clr2", 32'(irq), 32'h0);
`endif

    prescale = '0;
    out_en   = 16'hFFFF;
    pwm_en   = 16'h0000;
    step(3);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out", 32'(out), 32'h0);
    check("mid_rst_ps", 32'(period_start), 32'h0);
    step(2);
    rst_n = 1'b1;
    step(3);
    check("post_rst_out", 32'(out), 32'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
